recv: RTL and testbench
=======================

# recv

UART receiver for the DE2-115 serial link: the receive-side counterpart of the 8N1 transmitter already in the design. It synchronizes the asynchronous RXD line, finds the start bit, samples 8 data bits LSB-first at mid-bit and checks the stop bit. It then presents the byte on Dataout with a receive-interrupt flag RI, which the host logic acknowledges with RD. Framing errors and overruns are flagged.

## Interface
- DIV, 5208: clk cycles per bit (50 MHz / 9600 baud); legal range 16..65535.
- HALF, DIV/2 (integer division): start-bit validation offset in clk cycles.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- RXD  in  1  serial input, idle high, asynchronous to clk.
- RD  in  1  read acknowledge; 1-cycle pulse clears RI and OE.
- Dataout  out  8  last correctly framed byte; reset 8'h00.
- RI  out  1  receive flag, level; set on a valid frame; reset 0.
- FE  out  1  framing-error pulse, 1 cycle; reset 0.
- OE  out  1  overrun flag, sticky; reset 0.
- BUSY  out  1  high while a frame is in progress (state != IDLE); reset 0.

## Operation
- Input path: RXD -> s1 -> s2 (2-FF synchronizer) -> prev. s1, s2 and prev reset to 1. A start edge is detected when s2==0 && prev==1.
- Bit counter cnt is 16 bits wide. Bit index idx is 3 bits wide. The data shift register sh is 8 bits wide. The sample value smp is defined under Configuration.
- State machine:
  - IDLE: on a start edge -> START, cnt<=0.
  - START: cnt increments. When cnt==HALF-1: if smp==0 -> DATA with cnt<=0 and idx<=0; else -> IDLE (glitch rejected, no flags).
  - DATA: cnt increments. When cnt==DIV-1: sh<={smp,sh[7:1]}, cnt<=0. If idx==7 -> STOP, else idx<=idx+1.
  - STOP: cnt increments. When cnt==DIV-1:
    - smp==1: Dataout<=sh, RI<=1. If RI was already 1, OE<=1.
    - smp==0: FE<=1 for one cycle; Dataout, RI and OE are unchanged.
    - In both cases -> IDLE.
- IDLE is re-entered at mid-stop-bit, which leaves a half-bit margin for back-to-back frames. After a break (line held low), a new frame needs RXD to return high first, because the edge detector needs prev==1.
- RD: RI<=0 and OE<=0. If a valid stop and RD occur in the same cycle, the set wins: RI=1. OE then follows the RI value from before that cycle.
- RD has no effect on the state machine. RD while RI==0 is harmless.
- Asserting rst_n low at any point, including mid-frame, returns all registers to their reset values immediately. No RI or FE is produced for the aborted frame.

## Timing
- Take the RXD falling edge just before clk edge 0 as the reference:
  - s2 goes low at edge 2.
  - START is entered at edge 3.
  - DATA is entered at edge 3+HALF.
  - Bit k (k=0..7) is sampled at edge 3+HALF+(k+1)*DIV.
  - The stop bit is sampled at edge 3+HALF+9*DIV.
- RI/Dataout (or the FE pulse) become visible after edge 3+HALF+9*DIV. With the defaults this is edge 49479.
- BUSY is high from edge 3 through edge 3+HALF+9*DIV, and low after it.
- FE is high for exactly one cycle. RI clears on the cycle after the RD sample.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - A 3-bit history of s2 is kept.
  - smp is the majority of the last three s2 values at the sample point: 2-of-3.
  - A single-cycle glitch at a sample point is rejected.
  - Sample instants and latency are unchanged.
- UART_RX_MAJORITY_EN undefined: smp = s2 directly. There is no history register.

## Test plan
- Send 8N1 frame 0xA5 at DIV=5208 -> Dataout=8'hA5 and RI=1 after edge 49479 (ref RXD fall); FE=0, OE=0; RD pulse -> RI=0.
- Drive an RXD low pulse of HALF-10 cycles, then return high -> START then IDLE, BUSY returns 0, and RI, FE and Dataout are unchanged.
- Send 0x3C with the stop bit forced low -> one-cycle FE pulse at the stop sample; RI=0 and Dataout keeps its previous value.
- Send 0x00 and then 0xFF back-to-back with no RD -> RI=1, Dataout=8'hFF, OE=1; one RD pulse -> RI=0 and OE=0.
- Pull rst_n low during data bit 4 of a frame, then release -> all outputs are at reset values and no RI is produced; the next clean frame 0x5A is received correctly.
- With UART_RX_MAJORITY_EN: inject a 1-cycle inverted glitch on RXD exactly at the bit-3 sample point of frame 0x81 -> Dataout=8'h81. Without the macro, the same stimulus gives 8'h89.

Source files
------------

// File: rtl/recv.sv
// recv: 8N1 UART receiver with 2-FF sync, mid-bit sampling, RI/FE/OE flags.
// Optional UART_RX_MAJORITY_EN selects 2-of-3 majority sampling of RXD.
module recv #(
  parameter int DIV  = 5208,
  parameter int HALF = DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RXD,
  input  logic       RD,
  output logic [7:0] Dataout,
  output logic       RI,
  output logic       FE,
  output logic       OE,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  state_t      state, state_nx;
  logic        s1, s2, prev;
  logic [15:0] cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  sh, sh_nx;
  logic        smp;
  logic        frame_ok, frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= RXD;
      s2   <= s1;
      prev <= s2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist plus the current s2 form the 3-sample window
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], s2};
  end

  assign smp = (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign smp = s2;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    sh_nx     = sh;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (!s2 && prev) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          if (!smp) begin
            state_nx = DATA;
            cnt_nx   = '0;
            idx_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == DIV_M1) begin
          sh_nx  = {smp, sh[7:1]};
          cnt_nx = '0;
          if (idx == 3'd7) state_nx = STOP;
          else             idx_nx   = idx + 3'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == DIV_M1) begin
          frame_ok  = smp;
          frame_bad = ~smp;
          state_nx  = IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
    end
  end

  // a new frame beats a same-cycle RD; OE looks at RI before this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dataout <= '0;
      RI      <= 1'b0;
      FE      <= 1'b0;
      OE      <= 1'b0;
    end else begin
      FE <= frame_bad;
      if (frame_ok) Dataout <= sh;
      if (frame_ok)  RI <= 1'b1;
      else if (RD)   RI <= 1'b0;
      if (frame_ok && RI) OE <= 1'b1;
      else if (RD)        OE <= 1'b0;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_recv.sv
// tb_recv: directed self-checking bench for the recv UART receiver.
// Uses a short bit period so every scenario fits in a few thousand cycles.
module tb_recv;

  localparam int DIV  = 32;
  localparam int HALF = DIV / 2;
  localparam int S    = 3 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       ri, fe, oe, busy;

  int pass = 0;
  int total = 0;

  logic busy_a, busy_b, busy_c, busy_d;
  logic ri_a, ri_b, fe_a, fe_b, fe_c;

  recv #(.DIV(DIV), .HALF(HALF)) dut (
    .clk(clk), .rst_n(rst_n), .RXD(rxd), .RD(rd),
    .Dataout(dout), .RI(ri), .FE(fe), .OE(oe), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int glitch_c, input int rd_c,
                            input int abort_c);
    int bi;
    logic v;
    for (int c = 0; c < 10 * DIV; c++) begin
      @(negedge clk);
      if (c == 2) busy_a = busy;
      if (c == 3) busy_b = busy;
      if (c == S - 1) begin busy_c = busy; ri_a = ri; fe_a = fe; end
      if (c == S) begin busy_d = busy; ri_b = ri; fe_b = fe; end
      if (c == S + 1) fe_c = fe;
      if (c == abort_c) begin
        rst_n = 1'b0;
        rxd = 1'b1;
        break;
      end
      rd = (c == rd_c);
      bi = c / DIV;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop;
      else              v = d[bi-1];
      if (c == glitch_c) v = ~v;
      rxd = v;
    end
    if (abort_c < 0) begin
      @(negedge clk);
      rd = 1'b0;
      rxd = 1'b1;
    end
  endtask

  task automatic test_reset();
    total++; if (dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", dout); else pass++;
    total++; if (ri !== 1'b0) $display("FAIL rst_ri got %b exp 0", ri); else pass++;
    total++; if (fe !== 1'b0) $display("FAIL rst_fe got %b exp 0", fe); else pass++;
    total++; if (oe !== 1'b0) $display("FAIL rst_oe got %b exp 0", oe); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass++;
  endtask

  task automatic test_frame();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    total++; if (busy_a !== 1'b0) $display("FAIL busy_pre got %b exp 0", busy_a); else pass++;
    total++; if (busy_b !== 1'b1) $display("FAIL busy_start got %b exp 1", busy_b); else pass++;
    total++; if (busy_c !== 1'b1) $display("FAIL busy_end got %b exp 1", busy_c); else pass++;
    total++; if (busy_d !== 1'b0) $display("FAIL busy_post got %b exp 0", busy_d); else pass++;
    total++; if (ri_a !== 1'b0) $display("FAIL ri_early got %b exp 0", ri_a); else pass++;
    total++; if (ri_b !== 1'b1) $display("FAIL ri_on_time got %b exp 1", ri_b); else pass++;
    total++; if (dout !== 8'hA5) $display("FAIL a5_dout got %h exp a5", dout); else pass++;
    total++; if (fe_b !== 1'b0) $display("FAIL a5_fe got %b exp 0", fe_b); else pass++;
    total++; if (oe !== 1'b0) $display("FAIL a5_oe got %b exp 0", oe); else pass++;
    pulse_rd();
    total++; if (ri !== 1'b0) $display("FAIL a5_rd_ri got %b exp 0", ri); else pass++;
  endtask

  task automatic test_glitch_start();
    logic fe_seen = 1'b0;
    logic b_mid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 4) b_mid = busy;
      fe_seen |= fe;
      rxd = (c < HALF - 10) ? 1'b0 : 1'b1;
    end
    total++; if (b_mid !== 1'b1) $display("FAIL gl_busy_mid got %b exp 1", b_mid); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL gl_busy_end got %b exp 0", busy); else pass++;
    total++; if (fe_seen !== 1'b0) $display("FAIL gl_fe got %b exp 0", fe_seen); else pass++;
    total++; if (ri !== 1'b0) $display("FAIL gl_ri got %b exp 0", ri); else pass++;
    total++; if (dout !== 8'hA5) $display("FAIL gl_dout got %h exp a5", dout); else pass++;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    total++; if (fe_a !== 1'b0) $display("FAIL fe_early got %b exp 0", fe_a); else pass++;
    total++; if (fe_b !== 1'b1) $display("FAIL fe_pulse got %b exp 1", fe_b); else pass++;
    total++; if (fe_c !== 1'b0) $display("FAIL fe_width got %b exp 0", fe_c); else pass++;
    total++; if (ri !== 1'b0) $display("FAIL fe_ri got %b exp 0", ri); else pass++;
    total++; if (dout !== 8'hA5) $display("FAIL fe_dout got %h exp a5", dout); else pass++;
    idle(DIV);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1, -1);
    total++; if (ri !== 1'b1) $display("FAIL b2b_ri got %b exp 1", ri); else pass++;
    total++; if (dout !== 8'hFF) $display("FAIL b2b_dout got %h exp ff", dout); else pass++;
    total++; if (oe !== 1'b1) $display("FAIL b2b_oe got %b exp 1", oe); else pass++;
    pulse_rd();
    total++; if (ri !== 1'b0) $display("FAIL b2b_rd_ri got %b exp 0", ri); else pass++;
    total++; if (oe !== 1'b0) $display("FAIL b2b_rd_oe got %b exp 0", oe); else pass++;
  endtask

  task automatic test_rd_collision();
    send_frame(8'h11, 1'b1, -1, -1, -1);
    send_frame(8'h22, 1'b1, -1, S - 1, -1);
    total++; if (ri !== 1'b1) $display("FAIL col_ri got %b exp 1", ri); else pass++;
    total++; if (oe !== 1'b1) $display("FAIL col_oe got %b exp 1", oe); else pass++;
    total++; if (dout !== 8'h22) $display("FAIL col_dout got %h exp 22", dout); else pass++;
  endtask

  task automatic test_reset_abort();
    send_frame(8'h77, 1'b1, -1, -1, HALF + 5 * DIV);
    @(negedge clk);
    total++; if (dout !== 8'h00) $display("FAIL ab_dout got %h exp 00", dout); else pass++;
    total++; if (ri !== 1'b0) $display("FAIL ab_ri got %b exp 0", ri); else pass++;
    total++; if (oe !== 1'b0) $display("FAIL ab_oe got %b exp 0", oe); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL ab_busy got %b exp 0", busy); else pass++;
    idle(2);
    rst_n = 1'b1;
    idle(2 * DIV);
    total++; if (ri !== 1'b0) $display("FAIL ab_ri_late got %b exp 0", ri); else pass++;
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    total++; if (dout !== 8'h5A) $display("FAIL ab_5a_dout got %h exp 5a", dout); else pass++;
    total++; if (ri !== 1'b1) $display("FAIL ab_5a_ri got %b exp 1", ri); else pass++;
    pulse_rd();
  endtask

  task automatic test_majority();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'h81;
`else
    exp_d = 8'h89;
`endif
    send_frame(8'h81, 1'b1, HALF + 4 * DIV, -1, -1);
    total++; if (dout !== exp_d) $display("FAIL maj_dout got %h exp %h", dout, exp_d); else pass++;
  endtask

  initial begin
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(4);
    test_frame();
    idle(10);
    test_glitch_start();
    test_framing();
    test_back_to_back();
    idle(10);
    test_rd_collision();
    idle(10);
    test_reset_abort();
    idle(10);
    test_majority();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
